// File: rtl/morse_sym_ctrl.sv
// Morse symbol sequencing controller.
// Samples the key line on a prescaled tick enable, times mark/space runs,
// packs up to five dot/dash elements per character and hands each
// character downstream over valid/ready, pulsing once on a word gap.
module morse_sym_ctrl #(
  parameter int DIV        = 50000,
  parameter int CNT_W      = 8,
  parameter int DOT_MAX    = 2,
  parameter int LETTER_GAP = 3,
  parameter int WORD_GAP   = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  input  logic       char_ready,
  output logic       tick,
  output logic       char_valid,
  output logic [2:0] char_len,
  output logic [4:0] char_bits,
  output logic       char_err,
  output logic       word_pulse
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);
  localparam logic [CNT_W-1:0] RUN_MAX    = '1;
  localparam logic [CNT_W-1:0] RUN_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] DOT_LIM    = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] LGAP       = CNT_W'(LETTER_GAP);
  localparam logic [CNT_W-1:0] WGAP       = CNT_W'(WORD_GAP);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_SPACE,
    ST_HOLD,
    ST_GAP
  } state_t;

  state_t           state_reg;
  logic             key_meta_reg;
  logic             key_s_reg;
  logic [PW-1:0]    presc_reg;
  logic [CNT_W-1:0] run_reg;
  logic [2:0]       len_reg;
  logic [4:0]       bits_reg;
  logic             err_reg;
  logic             valid_reg;
  logic             word_pulse_reg;

  logic [CNT_W-1:0] run_inc;
  logic             sym;

  assign run_inc = run_reg + RUN_ONE;
  // A mark that ran beyond the dot limit (including a saturated run) is a dash.
  assign sym     = (run_reg > DOT_LIM);

  assign tick       = (presc_reg == PRESC_LAST);
  assign char_valid = valid_reg;
  assign char_len   = len_reg;
  assign char_bits  = bits_reg;
  assign char_err   = err_reg;
  assign word_pulse = word_pulse_reg;

  // Two-flop synchronizer for the asynchronous key line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_meta_reg <= 1'b0;
      key_s_reg    <= 1'b0;
    end else begin
      key_meta_reg <= key_in;
      key_s_reg    <= key_meta_reg;
    end
  end

  // Free-running prescaler; its terminal count is the sample enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_reg <= '0;
    end else if (presc_reg == PRESC_LAST) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + PW'(1);
    end
  end

  // Character state machine; advances on tick except for the handshake exit from HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      run_reg        <= '0;
      len_reg        <= '0;
      bits_reg       <= '0;
      err_reg        <= 1'b0;
      valid_reg      <= 1'b0;
      word_pulse_reg <= 1'b0;
    end else begin
      word_pulse_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (tick && key_s_reg) begin
            state_reg <= ST_MARK;
            run_reg   <= RUN_ONE;
            len_reg   <= '0;
            bits_reg  <= '0;
            err_reg   <= 1'b0;
          end
        end
        ST_MARK: begin
          if (tick) begin
            if (key_s_reg) begin
              run_reg <= (run_reg == RUN_MAX) ? run_reg : run_inc;
            end else begin
              if (len_reg < 3'd5) begin
                bits_reg <= bits_reg | (5'(sym) << len_reg);
                len_reg  <= len_reg + 3'd1;
              end else begin
                err_reg <= 1'b1;
              end
              state_reg <= ST_SPACE;
              run_reg   <= RUN_ONE;
            end
          end
        end
        ST_SPACE: begin
          if (tick) begin
            if (key_s_reg) begin
              state_reg <= ST_MARK;
              run_reg   <= RUN_ONE;
            end else begin
              run_reg <= run_inc;
              if (run_inc == LGAP) begin
                state_reg <= ST_HOLD;
                valid_reg <= 1'b1;
              end
            end
          end
        end
        ST_HOLD: begin
          // Key activity is ignored and the run count stays frozen until accepted.
          if (char_ready) begin
            state_reg <= ST_GAP;
            valid_reg <= 1'b0;
          end
        end
        ST_GAP: begin
          if (tick) begin
            if (key_s_reg) begin
              state_reg <= ST_MARK;
              run_reg   <= RUN_ONE;
              len_reg   <= '0;
              bits_reg  <= '0;
              err_reg   <= 1'b0;
            end else begin
              run_reg <= run_inc;
              if (run_inc == WGAP) begin
                state_reg      <= ST_IDLE;
                word_pulse_reg <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_sym_ctrl.sv
// Directed bench for morse_sym_ctrl: expected characters are queued as each
// one is keyed and compared when the DUT hands it over.
module tb_morse_sym_ctrl;

  localparam int DIV = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_in = 1'b0;
  logic       char_ready = 1'b1;
  logic       tick;
  logic       char_valid;
  logic [2:0] char_len;
  logic [4:0] char_bits;
  logic       char_err;
  logic       word_pulse;

  typedef struct {
    logic [2:0] len;
    logic [4:0] bits;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   wp_count = 0;
  int   acc_count = 0;
  int   valid_cycles = 0;

  morse_sym_ctrl #(
    .DIV(DIV), .CNT_W(8), .DOT_MAX(2), .LETTER_GAP(3), .WORD_GAP(7)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .char_ready(char_ready),
    .tick(tick), .char_valid(char_valid), .char_len(char_len),
    .char_bits(char_bits), .char_err(char_err), .word_pulse(word_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Monitor: counts pulses and valid cycles, pops and compares on each handshake.
  always @(negedge clk) begin
    if (rst) begin
      if (word_pulse) wp_count++;
      if (char_valid) valid_cycles++;
      if (char_valid && char_ready) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          failures++;
          $error("FAIL unexpected_char observed len=%0d bits=%b expected none", char_len, char_bits);
        end
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          $display("char %0d: len=%0d bits=%b err=%0d (exp len=%0d bits=%b err=%0d)",
                   acc_count, char_len, char_bits, char_err, mon_e.len, mon_e.bits, mon_e.err);
          check("char_len", 32'(char_len), 32'(mon_e.len));
          check("char_bits", 32'(char_bits), 32'(mon_e.bits));
          check("char_err", 32'(char_err), 32'(mon_e.err));
          acc_count++;
        end
      end
    end
  end

  // Hold the key at v for n sample periods; returns 1 time unit after a posedge.
  task automatic key_for(input logic v, input int n);
    key_in = v;
    repeat (n * DIV) @(posedge clk);
    #1;
  endtask

  // Key a pattern of '.'/'-', push the expected character, then hold the key up.
  task automatic send(input string pat, input int dot_t, input int dash_t, input int gap);
    exp_t e;
    int   n;
    n = pat.len();
    e.len  = (n > 5) ? 3'd5 : 3'(n);
    e.bits = '0;
    e.err  = (n > 5);
    for (int i = 0; i < n && i < 5; i++) e.bits[i] = (pat.getc(i) == 8'd45);
    exp_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      key_for(1'b1, (pat.getc(i) == 8'd45) ? dash_t : dot_t);
      if (i < n - 1) key_for(1'b0, 1);
    end
    key_for(1'b0, gap);
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   wp0, acc0, vc0, ticks, k;
    logic prev;

    // 1. Reset state and idle ticking.
    repeat (3) @(posedge clk);
    #1;
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_valid", 32'(char_valid), 32'd0);
    check("rst_len_bits", 32'({char_len, char_bits, char_err}), 32'd0);
    check("rst_word_pulse", 32'(word_pulse), 32'd0);
    rst = 1'b1;
    prev = tick;
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("tick_alternate", 32'(tick), 32'(!prev));
      prev = tick;
      if (tick) ticks++;
    end
    check("tick_count_20clk", 32'(ticks), 32'd10);
    check("idle_no_valid", 32'(valid_cycles), 32'd0);
    check("idle_no_pulse", 32'(wp_count), 32'd0);

    // 2 + 5. 'A', then a long space gives exactly one word pulse.
    wp0 = wp_count;
    send(".-", 1, 3, 3);
    wait_drain("a_drained");
    key_for(1'b0, 6);
    check("a_one_word_pulse", 32'(wp_count - wp0), 32'd1);
    key_for(1'b0, 10);
    check("a_no_extra_pulse", 32'(wp_count - wp0), 32'd1);

    // 3. 'E' held off by char_ready=0 for 10 clk.
    char_ready = 1'b0;
    send(".", 1, 3, 3);
    k = 0;
    while (!char_valid && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("e_valid_rise", 32'(char_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("e_hold_valid", 32'(char_valid), 32'd1);
      check("e_hold_len", 32'(char_len), 32'd1);
      check("e_hold_bits", 32'(char_bits), 32'd0);
    end
    char_ready = 1'b1;
    @(posedge clk);
    #1;
    check("e_valid_drop", 32'(char_valid), 32'd0);
    check("e_popped", 32'(exp_q.size()), 32'd0);
    key_for(1'b0, 10);

    // 4. Six dots: truncated to five with the error flag.
    send("......", 1, 3, 3);
    wait_drain("six_drained");
    key_for(1'b0, 10);

    // DOT_MAX boundary, mixed patterns and a saturating mark.
    send("..", 2, 3, 3);
    wait_drain("i_2tick_dots");
    key_for(1'b0, 10);
    send("-.-", 1, 3, 3);
    wait_drain("k_drained");
    key_for(1'b0, 10);
    send("-", 1, 300, 3);
    wait_drain("t_saturated");
    key_for(1'b0, 10);

    // Back-to-back characters inside a word: no pulse between them.
    wp0 = wp_count;
    send(".-", 1, 3, 3);
    wait_drain("a2_drained");
    key_for(1'b0, 2);
    send("-..", 1, 3, 3);
    wait_drain("d_drained");
    check("in_word_no_pulse", 32'(wp_count - wp0), 32'd0);
    key_for(1'b0, 10);

    // 6. Glitch between ticks, then reset mid-character.
    wp0 = wp_count;
    acc0 = acc_count;
    vc0 = valid_cycles;
    k = 0;
    while (tick && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    key_in = 1'b1;
    @(posedge clk);
    #1;
    key_in = 1'b0;
    key_for(1'b0, 12);
    check("glitch_no_valid", 32'(valid_cycles - vc0), 32'd0);
    check("glitch_no_pulse", 32'(wp_count - wp0), 32'd0);

    key_for(1'b1, 1);
    key_for(1'b0, 1);
    key_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midreset_outputs", 32'({tick, char_valid, char_len, char_bits, char_err, word_pulse}), 32'd0);
    key_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    check("post_reset_outputs", 32'({char_valid, char_len, char_bits, char_err, word_pulse}), 32'd0);
    key_for(1'b0, 20);
    check("post_reset_no_valid", 32'(valid_cycles - vc0), 32'd0);
    check("post_reset_no_pulse", 32'(wp_count - wp0), 32'd0);
    check("post_reset_no_char", 32'(acc_count - acc0), 32'd0);
    check("queue_empty_end", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
